loss_accum_unit: RTL and testbench

Multi-lane, multi-mode loss reduction engine and parametrised successor to the single-value L1 loss stage. It accepts a stream of LANES-wide predicted/target beats over a valid/ready handshake, computes per-element L1 or L2 loss, and reduces them into a saturating accumulator over a programmed number of beats. It sits after the activation/output path of the TPU datapath and returns one scalar loss per batch to the host-facing result path.

---
 rtl/loss_accum_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_loss_accum_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/loss_accum_unit.sv
// -----------------------------------------------------------------------------
// loss_accum_unit
//
// Multi-lane L1/L2 loss reduction engine. It accepts LANES-wide pred/targ
// beats over a valid/ready handshake and computes a per-element loss. It then
// reduces each beat to one lane sum and adds that sum into a saturating
// accumulator over cfg_len beats. The final scalar is returned over a
// valid/ready result port.
//
// Pipeline:
//   stage 1 : per-lane diff, |diff| (and diff^2 when L2 is enabled)
//   stage 2 : lane reduction register, then the accumulator register
// A beat accepted on edge E lands in the accumulator on edge E+2.
//
// Build option:
//   LOSS_L2_EN : when defined, cfg_mode selects L1 (0) or L2 (1) and the lane
//                multipliers are built. When undefined, only L1 is built and
//                cfg_mode is ignored.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, clear         begin batch (IDLE only) / synchronous abort
//   cfg_mode, cfg_len    loss mode and beat count, latched on start
//   in_valid, in_ready   input beat handshake
//   pred, targ           packed signed lanes, lane i = [i*DATA_W +: DATA_W]
//   sum_valid, sum_ready result handshake
//   loss_sum, overflow   accumulated loss, sticky saturation flag
//   busy                 high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module loss_accum_unit #(
   parameter int DATA_W = 32,
   parameter int LANES  = 4,
   parameter int ACC_W  = 48,
   parameter int LEN_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    clear,
   input  logic                    cfg_mode,
   input  logic [LEN_W-1:0]        cfg_len,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] pred,
   input  logic [LANES*DATA_W-1:0] targ,
   output logic                    sum_valid,
   input  logic                    sum_ready,
   output logic [ACC_W-1:0]        loss_sum,
   output logic                    overflow,
   output logic                    busy
);

   // Lane losses are built in a width that holds both a full square and the
   // accumulator. Saturation to ACC_W is then a single compare.
   localparam int PROD_W = 2 * (DATA_W + 1);
   localparam int WIDE_W = (PROD_W > ACC_W) ? PROD_W : ACC_W;
   localparam logic [WIDE_W-1:0] ACC_MAX_WIDE = {WIDE_W{1'b1}} >> (WIDE_W - ACC_W);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           r_state, w_next_state;
   logic [LEN_W-1:0] r_len, r_cnt;
   logic             r_s1_valid, r_s1_sat;
   logic [ACC_W-1:0] r_s1_loss [LANES];
   logic             r_s2_valid, r_s2_sat;
   logic [ACC_W-1:0] r_s2_sum;
   logic [ACC_W-1:0] r_acc;
   logic             r_ovf;
   logic             w_accept;

   // ---------------- stage 1: per-lane loss ----------------
   logic signed [DATA_W:0] w_diff      [LANES];
   logic        [DATA_W:0] w_mag       [LANES];
   logic [WIDE_W-1:0]      w_raw       [LANES];
   logic [ACC_W-1:0]       w_lane_loss [LANES];
   logic                   w_lane_sat;
`ifdef LOSS_L2_EN
   logic                   r_mode;
   logic [PROD_W-1:0]      w_mag_ext   [LANES];
`else
   logic                   w_unused_mode;
   assign w_unused_mode = cfg_mode;
`endif

   // NOTE: every combinational output gets a default before any branch, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_lane_sat = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         // Sign-extend by one bit so pred-targ can never wrap.
         w_diff[i] = $signed({pred[i*DATA_W + DATA_W - 1], pred[i*DATA_W +: DATA_W]})
                   - $signed({targ[i*DATA_W + DATA_W - 1], targ[i*DATA_W +: DATA_W]});
         w_mag[i]  = w_diff[i][DATA_W] ? $unsigned(-w_diff[i]) : $unsigned(w_diff[i]);
`ifdef LOSS_L2_EN
         // diff^2 == |diff|^2, so one unsigned multiplier per lane is enough.
         w_mag_ext[i] = PROD_W'(w_mag[i]);
         w_raw[i]     = r_mode ? WIDE_W'(w_mag_ext[i] * w_mag_ext[i]) : WIDE_W'(w_mag[i]);
`else
         w_raw[i]     = WIDE_W'(w_mag[i]);
`endif
         if (w_raw[i] > ACC_MAX_WIDE) begin
            w_lane_loss[i] = '1;
            w_lane_sat     = 1'b1;
         end else begin
            w_lane_loss[i] = w_raw[i][ACC_W-1:0];
         end
      end
   end

   // ---------------- stage 2: lane reduction and accumulate ----------------
   logic [ACC_W:0]   w_psum;
   logic [ACC_W-1:0] w_red;
   logic             w_red_sat;
   logic [ACC_W:0]   w_acc_sum;
   logic [ACC_W-1:0] w_acc_next;
   logic             w_acc_sat;

   always_comb begin
      w_psum    = '0;
      w_red     = '0;
      w_red_sat = r_s1_sat;
      for (int i = 0; i < LANES; i++) begin
         w_psum = {1'b0, w_red} + {1'b0, r_s1_loss[i]};
         if (w_psum[ACC_W]) begin
            w_red     = '1;
            w_red_sat = 1'b1;
         end else begin
            w_red = w_psum[ACC_W-1:0];
         end
      end
      w_acc_sum  = {1'b0, r_acc} + {1'b0, r_s2_sum};
      w_acc_sat  = w_acc_sum[ACC_W];
      w_acc_next = w_acc_sat ? '1 : w_acc_sum[ACC_W-1:0];
   end

   assign w_accept = in_valid && (r_state == S_RUN);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   // Pipeline lane registers are cleared on reset like the rest, which keeps
   // the reset state fully deterministic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len      <= '0;
         r_cnt      <= '0;
         r_s1_valid <= 1'b0;
         r_s1_sat   <= 1'b0;
         for (int i = 0; i < LANES; i++) r_s1_loss[i] <= '0;
         r_s2_valid <= 1'b0;
         r_s2_sat   <= 1'b0;
         r_s2_sum   <= '0;
         r_acc      <= '0;
         r_ovf      <= 1'b0;
`ifdef LOSS_L2_EN
         r_mode     <= 1'b0;
`endif
      end else if (clear) begin
         r_cnt      <= '0;
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_acc      <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_loss <= w_lane_loss;
            r_s1_sat  <= w_lane_sat;
         end
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_sum <= w_red;
            r_s2_sat <= w_red_sat;
         end
         if (r_state == S_IDLE && start) begin
            r_len <= cfg_len;
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
`ifdef LOSS_L2_EN
            r_mode <= cfg_mode;
`endif
         end else begin
            if (r_s2_valid) begin
               r_acc <= w_acc_next;
               r_ovf <= r_ovf | r_s2_sat | w_acc_sat;
            end
            if (w_accept) r_cnt <= r_cnt + LEN_W'(1);
         end
      end
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      sum_valid    = 1'b0;
      busy         = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_next_state = (cfg_len == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            in_ready = 1'b1;
            if (in_valid && (r_cnt == r_len - LEN_W'(1))) w_next_state = S_DRAIN;
         end
         S_DRAIN: begin
            if (!r_s1_valid && !r_s2_valid) w_next_state = S_DONE;
         end
         S_DONE: begin
            sum_valid = 1'b1;
            if (sum_ready) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
      if (clear) w_next_state = S_IDLE;
   end

   assign loss_sum = r_acc;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_loss_accum_unit.sv
// -----------------------------------------------------------------------------
// tb_loss_accum_unit
//
// Directed bench for loss_accum_unit. Two instances share all inputs:
//   dut   : default ACC_W=48
//   dut32 : ACC_W=32, for the saturation case
// Expected values are hand-computed constants. Inputs are driven, and outputs
// sampled, 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_loss_accum_unit;

   localparam int DATA_W = 32;
   localparam int LANES  = 4;
   localparam int LEN_W  = 16;

   logic                    clk = 1'b0;
   logic                    rst_n, start, clear, cfg_mode, in_valid, sum_ready;
   logic [LEN_W-1:0]        cfg_len;
   logic [LANES*DATA_W-1:0] pred, targ;

   logic        in_ready, sum_valid, overflow, busy;
   logic [47:0] loss_sum;
   logic        in_ready_32, sum_valid_32, overflow_32, busy_32;
   logic [31:0] loss_sum_32;

   int n_tests = 0;
   int n_fail  = 0;
   int cycles;

   always #5 clk = ~clk;

   loss_accum_unit #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(48), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .cfg_mode(cfg_mode),
      .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready), .pred(pred),
      .targ(targ), .sum_valid(sum_valid), .sum_ready(sum_ready), .loss_sum(loss_sum),
      .overflow(overflow), .busy(busy));

   loss_accum_unit #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(32), .LEN_W(LEN_W)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .cfg_mode(cfg_mode),
      .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready_32), .pred(pred),
      .targ(targ), .sum_valid(sum_valid_32), .sum_ready(sum_ready), .loss_sum(loss_sum_32),
      .overflow(overflow_32), .busy(busy_32));

   function automatic logic [127:0] pack4(input logic [31:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_batch(input logic mode, input logic [LEN_W-1:0] len);
      cfg_mode = mode;
      cfg_len  = len;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic send_beat(input logic [127:0] p, input logic [127:0] t);
      in_valid = 1'b1;
      pred     = p;
      targ     = t;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_sum(input int budget, output int n);
      n = 0;
      while (sum_valid !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic release_result(input string tag);
      sum_ready = 1'b1;
      tick();
      sum_ready = 1'b0;
      check_bit({tag, "_sv_drop"}, sum_valid, 1'b0);
      check_bit({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; clear = 1'b0; cfg_mode = 1'b0; cfg_len = '0;
      in_valid = 1'b0; pred = '0; targ = '0; sum_ready = 1'b0;

      // ---- reset state ----
      #2;
      check_bit("rst_in_ready", in_ready, 1'b0);
      check_bit("rst_sum_valid", sum_valid, 1'b0);
      check_bit("rst_overflow", overflow, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check_val("rst_loss_sum", 64'(loss_sum), 64'd0);
      check_bit("rst_busy_32", busy_32, 1'b0);
      #20 rst_n = 1'b1;
      tick();

      // ---- L1, two beats: 3+4+0+3 + 4*1 = 14 ----
      begin_batch(1'b0, 16'd2);
      check_bit("t1_busy", busy, 1'b1);
      check_bit("t1_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      pred = pack4(5, -3, 0, 7); targ = pack4(2, 1, 0, 10);
      tick();
      pred = pack4(1, 1, 1, 1);  targ = pack4(0, 0, 0, 0);
      tick();
      in_valid = 1'b0;
      pred = pack4(99, 99, 99, 99);
      check_bit("t1_drain_ready", in_ready, 1'b0);
      check_bit("t1_sv_e0", sum_valid, 1'b0);
      check_val("t1_acc_e0", 64'(loss_sum), 64'd0);
      tick();
      check_bit("t1_sv_e1", sum_valid, 1'b0);
      check_val("t1_acc_e1", 64'(loss_sum), 64'd10);
      tick();
      check_bit("t1_sv_e2", sum_valid, 1'b0);
      check_val("t1_acc_e2", 64'(loss_sum), 64'd14);
      tick();
      check_bit("t1_sv_e3", sum_valid, 1'b1);
      check_val("t1_loss", 64'(loss_sum), 64'd14);
      check_bit("t1_ovf", overflow, 1'b0);
      check_val("t1_loss_32", 64'(loss_sum_32), 64'd14);
      release_result("t1");
      check_val("t1_hold_idle", 64'(loss_sum), 64'd14);

      // ---- mode 1: L2 gives 9+16 = 25, L1-only build gives 3+4 = 7 ----
      begin_batch(1'b1, 16'd1);
      send_beat(pack4(3, -4, 0, 0), '0);
      wait_sum(20, cycles);
      check_val("t2_latency", 64'(cycles), 64'd3);
`ifdef LOSS_L2_EN
      check_val("t2_loss_l2", 64'(loss_sum), 64'd25);
`else
      check_val("t2_loss_l1only", 64'(loss_sum), 64'd7);
`endif
      check_bit("t2_ovf", overflow, 1'b0);
      release_result("t2");

      // ---- extremes: each lane |(-2^31) - (2^31-1)| = 2^32-1 ----
      begin_batch(1'b0, 16'd1);
      send_beat({4{32'h8000_0000}}, {4{32'h7FFF_FFFF}});
      wait_sum(20, cycles);
      check_val("t3_latency", 64'(cycles), 64'd3);
      check_val("t3_loss48", 64'(loss_sum), 64'h3_FFFF_FFFC);
      check_bit("t3_ovf48", overflow, 1'b0);
      check_val("t3_loss32", 64'(loss_sum_32), 64'hFFFF_FFFF);
      check_bit("t3_ovf32", overflow_32, 1'b1);
      check_bit("t3_sv32", sum_valid_32, 1'b1);
      release_result("t3");

      // ---- in_valid gaps, then result backpressure: 4*(1+2+3+4) = 40 ----
      begin_batch(1'b0, 16'd4);
      begin
         logic [6:0] pattern;
         int         k;
         pattern = 7'b1100101;   // bit 0 first
         k = 0;
         for (int s = 0; s < 7; s++) begin
            in_valid = pattern[s];
            if (pattern[s]) begin
               k++;
               pred = {4{32'(k)}};
            end else begin
               pred = {4{32'd1000}};
            end
            targ = '0;
            tick();
         end
         in_valid = 1'b0;
      end
      wait_sum(20, cycles);
      check_val("t4_latency", 64'(cycles), 64'd3);
      check_val("t4_loss", 64'(loss_sum), 64'd40);
      for (int c = 0; c < 10; c++) begin
         tick();
         check_bit("t4_hold_sv", sum_valid, 1'b1);
         check_val("t4_hold_loss", 64'(loss_sum), 64'd40);
         check_bit("t4_hold_ready", in_ready, 1'b0);
      end
      release_result("t4");

      // ---- cfg_len = 0 goes straight to DONE with a zero result ----
      begin_batch(1'b0, 16'd0);
      check_bit("t5_sv", sum_valid, 1'b1);
      check_val("t5_loss", 64'(loss_sum), 64'd0);
      check_bit("t5_ovf", overflow, 1'b0);
      release_result("t5");

      // ---- start during RUN is ignored: 4*2 + 4*3 = 20 ----
      begin_batch(1'b0, 16'd2);
      start = 1'b1; cfg_len = 16'd0;
      send_beat({4{32'd2}}, '0);
      start = 1'b0; cfg_len = 16'd2;
      check_bit("t6_still_run", in_ready, 1'b1);
      check_bit("t6_no_sv", sum_valid, 1'b0);
      send_beat({4{32'd3}}, '0);
      wait_sum(20, cycles);
      check_val("t6_latency", 64'(cycles), 64'd3);
      check_val("t6_loss", 64'(loss_sum), 64'd20);
      release_result("t6");

      // ---- clear after 3 of 8 beats, then a one-beat batch: 1+2+3+4 = 10 ----
      begin_batch(1'b0, 16'd8);
      in_valid = 1'b1; pred = {4{32'd100}}; targ = '0;
      tick(); tick(); tick();
      clear = 1'b1;
      tick();
      clear = 1'b0; in_valid = 1'b0;
      check_bit("t7_busy", busy, 1'b0);
      check_bit("t7_ready", in_ready, 1'b0);
      check_bit("t7_sv", sum_valid, 1'b0);
      check_val("t7_loss_zero", 64'(loss_sum), 64'd0);
      tick(); tick();
      check_val("t7_no_leak", 64'(loss_sum), 64'd0);
      begin_batch(1'b0, 16'd1);
      send_beat(pack4(1, 2, 3, 4), '0);
      wait_sum(20, cycles);
      check_val("t7_latency", 64'(cycles), 64'd3);
      check_val("t7_loss", 64'(loss_sum), 64'd10);
      check_val("t7_loss_32", 64'(loss_sum_32), 64'd10);
      check_bit("t7_ovf", overflow, 1'b0);
      release_result("t7");

      // ---- asynchronous reset in the middle of RUN ----
      begin_batch(1'b0, 16'd4);
      in_valid = 1'b1; pred = {4{32'd1}}; targ = '0;
      tick(); tick(); tick();
      in_valid = 1'b0;
      tick(); tick();
      check_val("t8_acc_mid", 64'(loss_sum), 64'd12);
      check_bit("t8_ready_mid", in_ready, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      check_bit("t8_rst_ready", in_ready, 1'b0);
      check_bit("t8_rst_busy", busy, 1'b0);
      check_bit("t8_rst_sv", sum_valid, 1'b0);
      check_bit("t8_rst_ovf", overflow, 1'b0);
      check_val("t8_rst_loss", 64'(loss_sum), 64'd0);
      check_val("t8_rst_loss32", 64'(loss_sum_32), 64'd0);
      check_bit("t8_rst_ready32", in_ready_32, 1'b0);
      rst_n = 1'b1;
      tick();
      check_bit("t8_after_busy", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
